div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_pkg.sv | 32 +++
 rtl/div_unit.sv | 191 +++++++++++++++++++
 tb/tb_div_unit.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// ---------------------------------------------------------------------------
// div_unit_pkg -- shared definitions for the iterative divider.
//
// Contents:
//   RegBusWidth / DoubleRegBusWidth : operand and result widths
//   DivFree / DivByZero / DivOn / DivEnd : divider FSM state encodings
//   DivResultReady / DivResultNotReady   : ready_o levels
//   DivLastIter : counter value at which all quotient bits are produced
//   twos_neg    : two's-complement negation of a 32-bit word
// ---------------------------------------------------------------------------
package div_unit_pkg;

    localparam int RegBusWidth       = 32;
    localparam int DoubleRegBusWidth = 64;

    localparam logic [1:0] DivFree   = 2'b00;
    localparam logic [1:0] DivByZero = 2'b01;
    localparam logic [1:0] DivOn     = 2'b10;
    localparam logic [1:0] DivEnd    = 2'b11;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    // Iterations run with the counter at 0..31; the cycle with the counter
    // at 32 does the sign fix-up and moves to DivEnd.
    localparam logic [5:0] DivLastIter = 6'd32;

    function automatic logic [RegBusWidth-1:0] twos_neg(input logic [RegBusWidth-1:0] v);
        return ~v + 32'd1;
    endfunction

endpackage

// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit -- 32-bit restoring divider (DIV / DIVU) for the EX stage.
//
// One quotient bit is produced per cycle. An accepted start gives ready_o
// 34 cycles later (2 cycles for a zero divisor). The result is held while
// start_i stays high and is cleared once start_i drops.
//
// Ports:
//   clk          in   pipeline clock, rising edge
//   rst          in   synchronous active-high reset
//   signed_div_i in   1 = signed (DIV), 0 = unsigned (DIVU)
//   opdata1_i    in   dividend (sampled only when accepted in DivFree)
//   opdata2_i    in   divisor  (sampled only when accepted in DivFree)
//   start_i      in   held high by EX from issue until result consumed
//   annul_i      in   pipeline flush; aborts an operation in DivOn/DivByZero
//   result_o     out  {remainder, quotient}
//   ready_o      out  result_o valid
// ---------------------------------------------------------------------------
module div_unit
    import div_unit_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         signed_div_i,
    input  logic [RegBusWidth-1:0]       opdata1_i,
    input  logic [RegBusWidth-1:0]       opdata2_i,
    input  logic                         start_i,
    input  logic                         annul_i,
    output logic [DoubleRegBusWidth-1:0] result_o,
    output logic                         ready_o
);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]                   state_reg,   state_next;
    logic [5:0]                   cnt_reg,     cnt_next;
    // quo_reg starts holding the dividend magnitude; each iteration shifts
    // its MSB into the partial remainder and shifts a quotient bit in at
    // the bottom, so after 32 iterations it holds the quotient magnitude.
    logic [RegBusWidth-1:0]       rem_reg,     rem_next;
    logic [RegBusWidth-1:0]       quo_reg,     quo_next;
    logic [RegBusWidth-1:0]       divisor_reg, divisor_next;
    // The latched signed_div_i is folded into these two flags: both are
    // zero in unsigned mode.
    logic                         neg_q_reg,   neg_q_next;
    logic                         neg_r_reg,   neg_r_next;
    logic [DoubleRegBusWidth-1:0] result_reg,  result_next;
    logic                         ready_reg,   ready_next;

    // -----------------------------------------------------------------------
    // Operand magnitudes (used at acceptance only)
    // -----------------------------------------------------------------------
    logic                   op1_neg;
    logic                   op2_neg;
    logic [RegBusWidth-1:0] op1_mag;
    logic [RegBusWidth-1:0] op2_mag;

    assign op1_neg = signed_div_i & opdata1_i[RegBusWidth-1];
    assign op2_neg = signed_div_i & opdata2_i[RegBusWidth-1];
    assign op1_mag = op1_neg ? twos_neg(opdata1_i) : opdata1_i;
    assign op2_mag = op2_neg ? twos_neg(opdata2_i) : opdata2_i;

    // -----------------------------------------------------------------------
    // Restoring shift-subtract step
    // -----------------------------------------------------------------------
    // The partial remainder is always below the divisor, so the shifted
    // trial value fits in 33 bits and, when the subtraction succeeds, the
    // difference fits back into 32 bits. Bit 33 of diff is the borrow.
    logic [RegBusWidth:0]   trial;
    logic [RegBusWidth+1:0] diff;
    logic                   fits;

    assign trial = {rem_reg, quo_reg[RegBusWidth-1]};
    assign diff  = {1'b0, trial} - {2'b00, divisor_reg};
    assign fits  = ~diff[RegBusWidth+1];

    // Signed fix-up applied on the final cycle in DivOn.
    logic [RegBusWidth-1:0] quo_fixed;
    logic [RegBusWidth-1:0] rem_fixed;

    assign quo_fixed = neg_q_reg ? twos_neg(quo_reg) : quo_reg;
    assign rem_fixed = neg_r_reg ? twos_neg(rem_reg) : rem_reg;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        rem_next     = rem_reg;
        quo_next     = quo_reg;
        divisor_next = divisor_reg;
        neg_q_next   = neg_q_reg;
        neg_r_next   = neg_r_reg;
        result_next  = result_reg;
        ready_next   = ready_reg;

        case (state_reg)
            DivFree: begin
                result_next = '0;
                ready_next  = DivResultNotReady;
                if (start_i && !annul_i) begin
                    cnt_next     = '0;
                    rem_next     = '0;
                    quo_next     = op1_mag;
                    divisor_next = op2_mag;
                    neg_q_next   = op1_neg ^ op2_neg;
                    neg_r_next   = op1_neg;
                    state_next   = (opdata2_i == '0) ? DivByZero : DivOn;
                end
            end

            DivByZero: begin
                if (annul_i) begin
                    state_next  = DivFree;
                    result_next = '0;
                    ready_next  = DivResultNotReady;
                end else begin
                    state_next  = DivEnd;
                    result_next = '0;
                    ready_next  = DivResultReady;
                end
            end

            DivOn: begin
                if (annul_i) begin
                    state_next  = DivFree;
                    result_next = '0;
                    ready_next  = DivResultNotReady;
                end else if (cnt_reg != DivLastIter) begin
                    rem_next = fits ? diff[RegBusWidth-1:0] : trial[RegBusWidth-1:0];
                    quo_next = {quo_reg[RegBusWidth-2:0], fits};
                    cnt_next = cnt_reg + 6'd1;
                end else begin
                    state_next  = DivEnd;
                    result_next = {rem_fixed, quo_fixed};
                    ready_next  = DivResultReady;
                    cnt_next    = '0;
                end
            end

            DivEnd: begin
                // annul_i is deliberately ignored here: the result has already
                // been produced and EX completes the handshake by dropping start.
                if (!start_i) begin
                    state_next  = DivFree;
                    result_next = '0;
                    ready_next  = DivResultNotReady;
                end
            end

            default: begin
                state_next  = DivFree;
                result_next = '0;
                ready_next  = DivResultNotReady;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= DivFree;
            cnt_reg     <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            divisor_reg <= '0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            result_reg  <= '0;
            ready_reg   <= DivResultNotReady;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            rem_reg     <= rem_next;
            quo_reg     <= quo_next;
            divisor_reg <= divisor_next;
            neg_q_reg   <= neg_q_next;
            neg_r_reg   <= neg_r_next;
            result_reg  <= result_next;
            ready_reg   <= ready_next;
        end
    end

    assign result_o = result_reg;
    assign ready_o  = ready_reg;

endmodule

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit -- self-checking bench for div_unit.
// Table-driven operations plus hand-written annul / reset / flush sequences.
// ---------------------------------------------------------------------------
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int checks = 0;
    int errors = 0;

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one operation with start held, scramble operands while it runs,
    // measure latency, check the held result (with an ignored annul pulse
    // in END) and the clear after start drops.
    task automatic run_op(input string name, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
        int   lat;
        logic got;
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            lat++;
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            signed_div_i = ~sgn;
            if (ready_o) got = 1'b1;
        end
        check({name, " latency"}, got ? 64'(lat) : 64'(0), 64'(exp_lat));
        check({name, " result"}, result_o, exp);
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        check({name, " hold ready"}, 64'(ready_o), 64'(1));
        check({name, " hold result"}, result_o, exp);
        start_i = 1'b0;
        @(negedge clk);
        check({name, " drop ready"}, 64'(ready_o), 64'(0));
        check({name, " drop result"}, result_o, 64'(0));
        $display("op %s sgn=%0d a=%h b=%h result=%h latency=%0d", name, sgn, a, b, exp, lat);
    endtask

    // Idle for n cycles with start low; ready_o must never rise.
    task automatic expect_idle(input string name, input int n);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (ready_o) seen = 1'b1;
        end
        check({name, " idle ready"}, 64'(seen), 64'(0));
    endtask

    initial begin
        vecs[0]  = '{1'b0, 32'd7,        32'd2,        {32'h00000001, 32'h00000003}, 34};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, 34};
        vecs[2]  = '{1'b0, 32'hFFFFFFF9, 32'd2,        {32'h00000001, 32'h7FFFFFFC}, 34};
        vecs[3]  = '{1'b0, 32'd7,        32'd0,        64'd0,                        2};
        vecs[4]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}, 34};
        vecs[5]  = '{1'b1, 32'd7,        32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 34};
        vecs[6]  = '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, {32'hFFFFFFFF, 32'h00000003}, 34};
        vecs[7]  = '{1'b0, 32'd5,        32'd7,        {32'h00000005, 32'h00000000}, 34};
        vecs[8]  = '{1'b0, 32'hFFFFFFFF, 32'd1,        {32'h00000000, 32'hFFFFFFFF}, 34};
        vecs[9]  = '{1'b1, 32'h80000000, 32'd0,        64'd0,                        2};
        vecs[10] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'h00000000, 32'h00000001}, 34};
        vecs[11] = '{1'b1, 32'h80000000, 32'd2,        {32'h00000000, 32'hC0000000}, 34};

        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        repeat (3) @(negedge clk);
        check("reset ready", 64'(ready_o), 64'(0));
        check("reset result", result_o, 64'(0));
        rst = 1'b0;
        opdata1_i = 32'd9;
        opdata2_i = 32'd3;
        expect_idle("free no start", 3);

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b,
                   vecs[i].exp, vecs[i].lat);
        end

        // Flush at iteration 10, then a fresh 100/7 with full latency.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        @(negedge clk);
        repeat (10) @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        check("annul ready", 64'(ready_o), 64'(0));
        check("annul result", result_o, 64'(0));
        expect_idle("after annul", 40);
        run_op("post_annul_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 34);

        // Reset at iteration 20 with start still high.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'hDEADBEEF;
        opdata2_i    = 32'h00001234;
        start_i      = 1'b1;
        @(negedge clk);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midop reset ready", 64'(ready_o), 64'(0));
        check("midop reset result", result_o, 64'(0));
        rst     = 1'b0;
        start_i = 1'b0;
        expect_idle("after reset", 40);
        run_op("post_reset_ffffffff_10", 1'b0, 32'hFFFFFFFF, 32'h10,
               {32'h0000000F, 32'h0FFFFFFF}, 34);

        // Flush while in the divide-by-zero state.
        @(negedge clk);
        opdata1_i = 32'd5;
        opdata2_i = 32'd0;
        start_i   = 1'b1;
        @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        check("byzero annul ready", 64'(ready_o), 64'(0));
        expect_idle("after byzero annul", 5);

        // start with annul in FREE must not be accepted.
        @(negedge clk);
        opdata1_i = 32'd50;
        opdata2_i = 32'd5;
        start_i   = 1'b1;
        annul_i   = 1'b1;
        expect_idle("free start+annul", 40);
        start_i = 1'b0;
        annul_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
